mips_mem_responder: RTL and testbench
=====================================

# mips_mem_responder

Byte-wide memory that sits at the other end of the multicycle MIPS core's memory bus. It answers the core's fetch and load reads combinationally, commits its stores on the clock edge, and reports each committed store on an observation port. After reset it runs a program-load phase. During that phase it accepts bytes from an external valid/ready stream and holds the core in reset. Once loading ends it releases the core to fetch from address 0.

## Interface
Parameters:
- WIDTH, 8, address and data width; DEPTH = 2**WIDTH bytes (256 at default)

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
- adr  input  WIDTH  core address (pc or aluout)
- writedata  input  WIDTH  core store data
- memread  input  1  core read strobe
- memwrite  input  1  core write strobe
- memdata  output  WIDTH  read data to core (combinational)
- cpu_reset  output  1  active-high synchronous reset to core
- ld_valid  input  1  loader byte valid
- ld_data  input  8  loader byte
- ld_last  input  1  marks final loader byte, qualified by ld_valid
- ld_ready  output  1  responder accepts loader byte this cycle
- st_valid  output  1  one-cycle pulse: store committed last edge
- st_adr  output  WIDTH  address of reported store
- st_data  output  WIDTH  data of reported store
- st_count  output  8  committed stores since reset, saturating at 255

## Operation
- State machine has two states: LOAD and RUN. reset forces LOAD.
- Reset values: ld_ptr=0, st_valid=0, st_adr=0, st_data=0, st_count=0. cpu_reset=1 and ld_ready=1 while in LOAD.
- Memory array has no reset. Reset leaves contents unchanged, and unloaded bytes keep their old values.
- LOAD behaviour:
  - A transfer occurs on a cycle with ld_valid & ld_ready. It writes mem[ld_ptr] <= ld_data and increments ld_ptr modulo DEPTH.
  - A transfer with ld_last=1, or with ld_ptr==DEPTH-1, moves the FSM to RUN.
  - ld_last without ld_valid is ignored.
  - memwrite is ignored and memdata=0.
- RUN behaviour:
  - ld_ready=0 and cpu_reset=0; ld_valid is ignored. RUN persists until reset.
  - memdata = mem[adr] when memread=1, else 0.
  - memwrite=1 writes mem[adr] <= writedata at the edge. On the next cycle st_valid=1, st_adr=adr and st_data=writedata. st_count increments unless it is already 255.
- Reads are read-before-write: when memread and memwrite are both high, memdata shows the old byte. The core never does this, but the behaviour is defined anyway.
- ld_ptr wraps to 0 only through reset. Reaching DEPTH-1 always ends LOAD.

## Timing
- Read latency is 0 cycles. memdata is combinational from adr/memread so the core's instruction and data registers capture it at the same edge.
- Write latency is 1 edge. A read of the same address on the following cycle returns the new byte.
- st_valid is high for exactly one cycle per store. Back-to-back stores produce back-to-back pulses.
- LOAD to RUN:
  - The edge that accepts the final byte moves the FSM to RUN, so cpu_reset and ld_ready read 0 from the next cycle.
  - The core saw cpu_reset=1 at that edge, so it starts in FETCH1 with pc=0 in the first RUN cycle. The first fetch sees the loaded mem[0].
- Reset asserted mid-RUN: the next cycle is LOAD with cpu_reset=1, ld_ptr=0 and st_count=0. A store on that same edge is suppressed: no write, no st_valid. Memory otherwise retained.
- Reset asserted mid-LOAD: any transfer on that edge is dropped and ld_ptr returns to 0.

## Test plan
- Load bytes 8'h80,8'h01,8'h02,8'h03 with ld_last on the 4th byte. Required response:
  - ld_ready=1 and cpu_reset=1 during the load.
  - Both ld_ready and cpu_reset read 0 on the cycle after the 4th byte.
  - With memread=1 and adr=0..3, memdata reads 80,01,02,03.
- Loader gaps: drive ld_valid low on alternate cycles over 3 bytes. Required response: ld_ptr advances only on valid cycles, giving mem[0..2] correct with no skipped or duplicated byte.
- RUN store: memwrite=1, adr=8'h10, writedata=8'hA5. Required response:
  - Next cycle st_valid=1, st_adr=10, st_data=A5, st_count=1.
  - memread at adr=10 returns A5.
  - The same store attempted during LOAD has no effect.
- Full load: stream 256 bytes with no ld_last, value = address XOR 8'h5A. Required response: RUN is entered after byte 255, and mem[255] reads A5.
- Read-before-write: memread=memwrite=1, adr=8'h20 holding 8'h11, writedata=8'h22. Required response: memdata=11 that cycle and 22 on the next cycle.
- Counter saturation and mid-RUN reset: issue 260 stores. Required response:
  - st_count holds at 255.
  - Pulsing reset in RUN gives cpu_reset=1, st_count=0 and ld_ready=1 the next cycle, with memory contents retained.

Source files
------------

// File: rtl/mips_mem_responder.sv
// Byte-wide memory responder for the multicycle MIPS core: loads a program from a
// valid/ready byte stream while holding the core in reset, then serves reads and stores.
module mips_mem_responder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    input  logic             memread,
    input  logic             memwrite,
    output logic [WIDTH-1:0] memdata,
    output logic             cpu_reset,
    input  logic             ld_valid,
    input  logic [7:0]       ld_data,
    input  logic             ld_last,
    output logic             ld_ready,
    output logic             st_valid,
    output logic [WIDTH-1:0] st_adr,
    output logic [WIDTH-1:0] st_data,
    output logic [7:0]       st_count
);

    localparam int DEPTH = 2**WIDTH;

    typedef enum logic {LOAD, RUN} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] ld_ptr;
    logic             ld_xfer;
    logic             st_we;

    always_ff @(posedge clk) begin
        if (reset) state <= LOAD;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == LOAD && ld_valid && (ld_last || ld_ptr == '1))
            state_next = RUN;
    end

    always_comb begin
        cpu_reset = (state == LOAD);
        ld_ready  = (state == LOAD);
        ld_xfer   = (state == LOAD) && ld_valid;
        st_we     = (state == RUN) && memwrite;
        memdata   = ((state == RUN) && memread) ? mem[adr] : '0;
    end

    // No reset on the array: contents survive reset, and a write on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (ld_xfer)
                mem[ld_ptr] <= WIDTH'(ld_data);
            else if (st_we)
                mem[adr] <= writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_ptr   <= '0;
            st_valid <= 1'b0;
            st_adr   <= '0;
            st_data  <= '0;
            st_count <= '0;
        end else begin
            st_valid <= st_we;
            if (ld_xfer)
                ld_ptr <= ld_ptr + WIDTH'(1);
            if (st_we) begin
                st_adr  <= adr;
                st_data <= writedata;
                if (st_count != 8'hFF)
                    st_count <= st_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Randomised and directed bench for mips_mem_responder, checked every cycle against a
// behavioural byte-array model plus a few literal expectations.
module tb_mips_mem_responder;

    logic       clk;
    logic       reset;
    logic [7:0] adr;
    logic [7:0] writedata;
    logic       memread;
    logic       memwrite;
    logic [7:0] memdata;
    logic       cpu_reset;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_last;
    logic       ld_ready;
    logic       st_valid;
    logic [7:0] st_adr;
    logic [7:0] st_data;
    logic [7:0] st_count;

    int tests = 0;
    int fails = 0;

    mips_mem_responder #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .adr       (adr),
        .writedata (writedata),
        .memread   (memread),
        .memwrite  (memwrite),
        .memdata   (memdata),
        .cpu_reset (cpu_reset),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .st_valid  (st_valid),
        .st_adr    (st_adr),
        .st_data   (st_data),
        .st_count  (st_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model
    bit       started = 0;
    bit       loading = 1;
    int       ptr = 0;
    int       count = 0;
    bit [7:0] m [256];
    bit       known [256];
    bit       exp_st_valid = 0;
    bit [7:0] exp_st_adr = 0;
    bit [7:0] exp_st_data = 0;

    always @(posedge clk) begin
        exp_st_valid = 0;
        if (reset) begin
            started = 1;
            loading = 1;
            ptr = 0;
            count = 0;
        end else if (loading) begin
            if (ld_valid) begin
                m[ptr] = ld_data;
                known[ptr] = 1;
                if (ld_last || ptr == 255) loading = 0;
                ptr = (ptr + 1) % 256;
            end
        end else if (memwrite) begin
            m[adr] = writedata;
            known[adr] = 1;
            exp_st_valid = 1;
            exp_st_adr = adr;
            exp_st_data = writedata;
            if (count < 255) count = count + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("cpu_reset", {31'd0, cpu_reset}, {31'd0, loading});
            check("ld_ready", {31'd0, ld_ready}, {31'd0, loading});
            check("st_valid", {31'd0, st_valid}, {31'd0, exp_st_valid});
            check("st_count", {24'd0, st_count}, count);
            if (exp_st_valid) begin
                check("st_adr", {24'd0, st_adr}, {24'd0, exp_st_adr});
                check("st_data", {24'd0, st_data}, {24'd0, exp_st_data});
            end
            if (loading || !memread)
                check("memdata_zero", {24'd0, memdata}, 32'd0);
            else if (known[adr])
                check("memdata", {24'd0, memdata}, {24'd0, m[adr]});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        ld_valid = 0;
        memwrite = 0;
        tick();
        reset = 0;
    endtask

    task automatic load_byte(input logic [7:0] d, input logic last);
        ld_valid = 1;
        ld_data = d;
        ld_last = last;
        tick();
        ld_valid = 0;
        ld_last = 0;
    endtask

    task automatic read_check(input string name, input logic [7:0] a, input logic [7:0] e);
        memread = 1;
        adr = a;
        @(negedge clk);
        check(name, {24'd0, memdata}, {24'd0, e});
        tick();
        memread = 0;
    endtask

    task automatic store(input logic [7:0] a, input logic [7:0] d);
        memwrite = 1;
        adr = a;
        writedata = d;
        tick();
        memwrite = 0;
    endtask

    initial begin
        logic [7:0] prog [4];
        logic [7:0] gapv [3];
        prog[0] = 8'h80; prog[1] = 8'h01; prog[2] = 8'h02; prog[3] = 8'h03;
        gapv[0] = 8'h33; gapv[1] = 8'h44; gapv[2] = 8'h55;
        reset = 1; adr = 0; writedata = 0; memread = 0; memwrite = 0;
        ld_valid = 0; ld_data = 0; ld_last = 0;

        // Reset state
        tick();
        reset = 0;
        @(negedge clk);
        check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
        check("rst_st_valid", {31'd0, st_valid}, 32'd0);
        check("rst_st_count", {24'd0, st_count}, 32'd0);
        check("rst_st_adr", {24'd0, st_adr}, 32'd0);
        check("rst_st_data", {24'd0, st_data}, 32'd0);
        tick();

        // Four-byte program load
        for (int i = 0; i < 4; i++) load_byte(prog[i], i == 3);
        @(negedge clk);
        check("run_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check("run_ld_ready", {31'd0, ld_ready}, 32'd0);
        tick();
        for (int i = 0; i < 4; i++) read_check("prog_read", 8'(i), prog[i]);

        // RUN store and report
        store(8'h10, 8'hA5);
        @(negedge clk);
        check("store_st_valid", {31'd0, st_valid}, 32'd1);
        check("store_st_adr", {24'd0, st_adr}, 32'h10);
        check("store_st_data", {24'd0, st_data}, 32'hA5);
        check("store_st_count", {24'd0, st_count}, 32'd1);
        tick();
        read_check("store_read", 8'h10, 8'hA5);

        // Load with gaps; ld_last without valid and stores during LOAD are ignored
        do_reset();
        for (int i = 0; i < 3; i++) begin
            ld_valid = 0; ld_last = 1;
            memwrite = 1; adr = 8'h10; writedata = 8'h00;
            tick();
            ld_last = 0;
            load_byte(gapv[i], i == 2);
        end
        memwrite = 0;
        for (int i = 0; i < 3; i++) read_check("gap_read", 8'(i), gapv[i]);
        read_check("load_store_ignored", 8'h10, 8'hA5);

        // Full 256-byte load without ld_last
        do_reset();
        for (int i = 0; i < 256; i++) load_byte(8'(i) ^ 8'h5A, 1'b0);
        @(negedge clk);
        check("full_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        tick();
        read_check("full_read_ff", 8'hFF, 8'hA5);
        read_check("full_read_00", 8'h00, 8'h5A);

        // Read-before-write
        store(8'h20, 8'h11);
        memread = 1; memwrite = 1; adr = 8'h20; writedata = 8'h22;
        @(negedge clk);
        check("rbw_old", {24'd0, memdata}, 32'h11);
        tick();
        memwrite = 0;
        @(negedge clk);
        check("rbw_new", {24'd0, memdata}, 32'h22);
        tick();
        memread = 0;

        // Random RUN traffic
        for (int i = 0; i < 200; i++) begin
            memread = 1'($urandom % 2);
            memwrite = ($urandom % 4) == 0;
            adr = 8'($urandom);
            writedata = 8'($urandom);
            ld_valid = 1'($urandom % 2);
            ld_data = 8'($urandom);
            tick();
        end
        memwrite = 0; ld_valid = 0; memread = 0;

        // Counter saturation, then reset with a suppressed store
        for (int i = 0; i < 260; i++) store(8'($urandom), 8'($urandom));
        @(negedge clk);
        check("sat_st_count", {24'd0, st_count}, 32'd255);
        tick();
        store(8'h30, 8'h99);
        reset = 1; memwrite = 1; adr = 8'h30; writedata = 8'h77;
        tick();
        reset = 0; memwrite = 0;
        @(negedge clk);
        check("mrst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("mrst_ld_ready", {31'd0, ld_ready}, 32'd1);
        check("mrst_st_count", {24'd0, st_count}, 32'd0);
        check("mrst_st_valid", {31'd0, st_valid}, 32'd0);
        tick();
        load_byte(8'hC3, 1'b1);
        read_check("mrst_retained", 8'h30, 8'h99);
        read_check("mrst_reload", 8'h00, 8'hC3);

        // Random mixed traffic with occasional resets, including mid-load
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom % 64) == 0;
            ld_valid = 1'($urandom % 2);
            ld_data = 8'($urandom);
            ld_last = ($urandom % 16) == 0;
            memread = 1'($urandom % 2);
            memwrite = ($urandom % 3) == 0;
            adr = 8'($urandom);
            writedata = 8'($urandom);
            tick();
        end
        reset = 0; ld_valid = 0; ld_last = 0; memread = 0; memwrite = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
